// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM-stage load/store unit and the data memory.
// Word-wide, single outstanding request, slave acknowledges with a one-cycle ack.
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage load/store unit: alignment check, one bus transaction per request,
// byte-lane select and sign/zero extension of load data, timeout abort.
module mem_access #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  mem_access_if.master mbus
);

  localparam logic [3:0] OP_LW  = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                         OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH  = 4'd7, OP_SB = 4'd8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] lane;
  } req_t;

  state_t     state;
  req_t       req_q;
  logic [7:0] wait_cnt;

  // Request decode, evaluated only while IDLE.
  logic        is_mem, misaligned, is_store;
  logic [3:0]  be_n;
  logic [31:0] wd_n;

  always_comb begin
    is_mem     = 1'b0;
    misaligned = 1'b0;
    be_n       = 4'b0000;
    wd_n       = 32'h0;
    case (mem_op)
      OP_LW, OP_SW: begin
        is_mem     = 1'b1;
        misaligned = |addr[1:0];
        be_n       = 4'b1111;
        wd_n       = wdata;
      end
      OP_LH, OP_LHU, OP_SH: begin
        is_mem     = 1'b1;
        misaligned = addr[0];
        be_n       = addr[1] ? 4'b1100 : 4'b0011;
        wd_n       = {2{wdata[15:0]}};
      end
      OP_LB, OP_LBU, OP_SB: begin
        is_mem = 1'b1;
        be_n   = 4'b0001 << addr[1:0];
        wd_n   = {4{wdata[7:0]}};
      end
      default: ;
    endcase
    is_store = (mem_op == OP_SW) || (mem_op == OP_SH) || (mem_op == OP_SB);
  end

  // Lane select and extension of the returned word, using the latched request.
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] ld_val;

  always_comb begin
    sel_b = 8'(mbus.bus_rdata >> {req_q.lane, 3'b000});
    sel_h = req_q.lane[1] ? mbus.bus_rdata[31:16] : mbus.bus_rdata[15:0];
    case (req_q.op)
      OP_LH:   ld_val = {{16{sel_h[15]}}, sel_h};
      OP_LHU:  ld_val = {16'h0, sel_h};
      OP_LB:   ld_val = {{24{sel_b[7]}}, sel_b};
      OP_LBU:  ld_val = {24'h0, sel_b};
      default: ld_val = mbus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_q          <= '0;
      wait_cnt       <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      rdata          <= 32'h0;
      addr_err       <= 1'b0;
      bus_err        <= 1'b0;
      mbus.bus_req   <= 1'b0;
      mbus.bus_we    <= 1'b0;
      mbus.bus_addr  <= 32'h0;
      mbus.bus_be    <= 4'b0000;
      mbus.bus_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          addr_err <= is_mem & misaligned;
          bus_err  <= 1'b0;
          if (is_mem && !misaligned) begin
            state          <= ACCESS;
            req_q          <= '{op: mem_op, lane: addr[1:0]};
            wait_cnt       <= 8'd0;
            mbus.bus_req   <= 1'b1;
            mbus.bus_we    <= is_store;
            mbus.bus_addr  <= {addr[31:2], 2'b00};
            mbus.bus_be    <= be_n;
            mbus.bus_wdata <= wd_n;
          end else begin
            // nop or misaligned: complete without touching the bus
            state <= RESP;
            done  <= 1'b1;
          end
        end
        ACCESS: begin
          // an ack on the final allowed cycle still wins over the timeout
          if (mbus.bus_ack) begin
            state        <= RESP;
            done         <= 1'b1;
            mbus.bus_req <= 1'b0;
            if (!mbus.bus_we) rdata <= ld_val;
          end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            state        <= RESP;
            done         <= 1'b1;
            mbus.bus_req <= 1'b0;
            bus_err      <= 1'b1;
            rdata        <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, reset-abort sequence, and
// random requests checked against an arithmetic reference model.
module tb_mem_access;
  localparam int MAXW = 4;

  logic        clk, rst_n, start;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, addr_err, bus_err;

  mem_access_if bus_if();

  mem_access #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .addr_err(addr_err), .bus_err(bus_err), .mbus(bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, wd, rw;
    int          dly;
    bit          poke;
    int          lat, nreq;
    logic [31:0] rd;
    bit          ae, berr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] baddr, bwd;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, wd, rw,
                              input int dly, input bit poke, input int lat, nreq,
                              input logic [31:0] rd, input bit ae, berr,
                              input logic [3:0] be, input bit we,
                              input logic [31:0] baddr, bwd);
    vec_t v;
    v.op = op; v.a = a; v.wd = wd; v.rw = rw; v.dly = dly; v.poke = poke;
    v.lat = lat; v.nreq = nreq; v.rd = rd; v.ae = ae; v.berr = berr;
    v.be = be; v.we = we; v.baddr = baddr; v.bwd = bwd;
    return v;
  endfunction

  // Reference: access size in bytes, alignment by modulo, lanes by shifting.
  function automatic vec_t model(input vec_t v);
    int     sz;
    bit     ld, sgn;
    longint mask, f;
    case (v.op)
      4'd1, 4'd6:       sz = 4;
      4'd2, 4'd3, 4'd7: sz = 2;
      4'd4, 4'd5, 4'd8: sz = 1;
      default:          sz = 0;
    endcase
    ld  = (v.op >= 4'd1) && (v.op <= 4'd5);
    sgn = (v.op == 4'd2) || (v.op == 4'd4);
    v.ae = (sz != 0) && ((v.a % sz) != 0);
    v.berr = 0; v.rd = 0; v.be = 0; v.we = 0; v.baddr = 0; v.bwd = 0;
    if (sz == 0 || v.ae) begin
      v.lat = 1; v.nreq = 0;
      return v;
    end
    mask    = (64'd1 << (8 * sz)) - 1;
    v.we    = !ld;
    v.baddr = v.a & ~32'h3;
    v.be    = 4'(((1 << sz) - 1) << (v.a % 4));
    f = 0;
    for (int k = 0; k < 4 / sz; k++) f = f | ((longint'(v.wd) & mask) << (8 * sz * k));
    v.bwd = 32'(f);
    if (v.dly >= MAXW) begin
      v.nreq = MAXW; v.lat = MAXW + 1; v.berr = 1; v.rd = 0;
    end else begin
      v.nreq = v.dly + 1; v.lat = v.dly + 2;
      if (ld) begin
        f = (longint'(v.rw) >> (8 * (v.a % 4))) & mask;
        if (sgn && f[8 * sz - 1]) f = f - (64'd1 << (8 * sz));
        v.rd = 32'(f);
      end
    end
    return v;
  endfunction

  // Called one step after a rising edge with the DUT idle; acts as bus slave.
  task automatic do_op(input vec_t v, output vec_t g, output bit stable,
                       output bit busy_d, output bit done_after, output bit busy_after);
    bit cap;
    g = v; g.lat = -1; g.nreq = 0; stable = 1; cap = 0; busy_d = 0;
    start = 1'b1; mem_op = v.op; addr = v.a; wdata = v.wd;
    @(posedge clk); #1;
    start = 1'b0; mem_op = 4'($urandom); addr = $urandom; wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus_if.bus_req) begin
        g.nreq++;
        if (!cap) begin
          cap = 1; g.be = bus_if.bus_be; g.we = bus_if.bus_we;
          g.baddr = bus_if.bus_addr; g.bwd = bus_if.bus_wdata;
        end else if ({bus_if.bus_be, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}
                     !== {g.be, g.we, g.baddr, g.bwd}) stable = 0;
        if (g.nreq == v.dly + 1) begin
          bus_if.bus_ack = 1'b1; bus_if.bus_rdata = v.rw;
        end
        if (v.poke && g.nreq == 1) begin
          start = 1'b1; mem_op = 4'd1; addr = 32'h0;
        end
      end
      if (done) begin
        g.lat = c; g.rd = rdata; g.ae = addr_err; g.berr = bus_err; busy_d = busy;
        bus_if.bus_ack = 1'b1;  // stray ack while responding must be ignored
      end
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom; start = 1'b0;
      if (g.lat == c) break;
    end
    done_after = done; busy_after = busy;
  endtask

  task automatic apply_check(input string tag, input vec_t e);
    vec_t g;
    bit   st, bd, da, ba;
    bit   is_ld;
    do_op(e, g, st, bd, da, ba);
    is_ld = (e.op >= 4'd1) && (e.op <= 4'd5);
    chk({tag, ".latency"},  32'(g.lat),  32'(e.lat));
    chk({tag, ".req_cycles"}, 32'(g.nreq), 32'(e.nreq));
    chk({tag, ".addr_err"}, 32'(g.ae),   32'(e.ae));
    chk({tag, ".bus_err"},  32'(g.berr), 32'(e.berr));
    chk({tag, ".busy_at_done"}, 32'(bd), 32'd1);
    chk({tag, ".done_pulse"}, {30'h0, da, ba}, 32'd0);
    if (e.nreq > 0) begin
      chk({tag, ".bus_be"},   32'(g.be),  32'(e.be));
      chk({tag, ".bus_we"},   32'(g.we),  32'(e.we));
      chk({tag, ".bus_addr"}, g.baddr,    e.baddr);
      chk({tag, ".bus_stable"}, 32'(st),  32'd1);
      if (e.we) chk({tag, ".bus_wdata"}, g.bwd, e.bwd);
      if (is_ld || e.berr) chk({tag, ".rdata"}, g.rd, e.rd);
    end
    if (g.lat < 0) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  vec_t tbl[$];

  initial begin
    bit seen_done;
    vec_t v;

    rst_n = 1'b0; start = 1'b0; mem_op = 4'd0; addr = 32'h0; wdata = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset.ctrl", {26'h0, busy, done, bus_if.bus_req, bus_if.bus_we, addr_err, bus_err}, 32'h0);
    chk("reset.bus_addr", bus_if.bus_addr, 32'h0);
    chk("reset.bus_be", 32'(bus_if.bus_be), 32'h0);
    chk("reset.bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("reset.rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //          op     addr          wdata         rword         dly poke lat nreq rdata         ae berr be       we baddr         bwdata
    tbl.push_back(mk(4'd1, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 2, 0, 4, 3, 32'hDEAD_BEEF, 0, 0, 4'b1111, 0, 32'h0000_0104, 32'h0));
    tbl.push_back(mk(4'd4, 32'h0000_0203, 32'h0,         32'h8A00_0000, 0, 0, 2, 1, 32'hFFFF_FF8A, 0, 0, 4'b1000, 0, 32'h0000_0200, 32'h0));
    tbl.push_back(mk(4'd5, 32'h0000_0203, 32'h0,         32'h8A00_0000, 0, 0, 2, 1, 32'h0000_008A, 0, 0, 4'b1000, 0, 32'h0000_0200, 32'h0));
    tbl.push_back(mk(4'd7, 32'h0000_0012, 32'h1234_ABCD, 32'h0,         1, 0, 3, 2, 32'h0,         0, 0, 4'b1100, 1, 32'h0000_0010, 32'hABCD_ABCD));
    tbl.push_back(mk(4'd1, 32'h0000_0006, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         1, 0, 4'b0000, 0, 32'h0,         32'h0));
    tbl.push_back(mk(4'd8, 32'h0000_0006, 32'h0000_0055, 32'h0,         0, 0, 2, 1, 32'h0,         0, 0, 4'b0100, 1, 32'h0000_0004, 32'h5555_5555));
    tbl.push_back(mk(4'd6, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,        99, 1, 5, 4, 32'h0,         0, 1, 4'b1111, 1, 32'h0000_0020, 32'hCAFE_F00D));
    tbl.push_back(mk(4'd0, 32'h0000_0030, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         0, 0, 4'b0000, 0, 32'h0,         32'h0));
    tbl.push_back(mk(4'd12, 32'h0000_0031, 32'h0,        32'h0,         0, 0, 1, 0, 32'h0,         0, 0, 4'b0000, 0, 32'h0,         32'h0));
    tbl.push_back(mk(4'd2, 32'h0000_0002, 32'h0,         32'h8001_0000, 3, 0, 5, 4, 32'hFFFF_8001, 0, 0, 4'b1100, 0, 32'h0000_0000, 32'h0));
    tbl.push_back(mk(4'd7, 32'h0000_0001, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0,         1, 0, 4'b0000, 0, 32'h0,         32'h0));
    tbl.push_back(mk(4'd3, 32'h0000_0102, 32'h0,         32'h7F80_0001, 0, 1, 2, 1, 32'h0000_7F80, 0, 0, 4'b1100, 0, 32'h0000_0100, 32'h0));

    foreach (tbl[i]) apply_check($sformatf("tbl%0d", i), tbl[i]);

    // Reset while a store waits for ack: request drops at once, no completion.
    start = 1'b1; mem_op = 4'd6; addr = 32'h0000_0040; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("rst.req_before", 32'(bus_if.bus_req), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst.req_async", {30'h0, bus_if.bus_req, busy}, 32'd0);
    seen_done = 0;
    repeat (2) begin @(negedge clk); seen_done |= done; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); seen_done |= done | bus_if.bus_req; end
    chk("rst.no_done", 32'(seen_done), 32'd0);
    @(posedge clk); #1;
    apply_check("rst.lhu", mk(4'd3, 32'h0000_0002, 32'h0, 32'hF00D_0000, 0, 0, 2, 1,
                              32'h0000_F00D, 0, 0, 4'b1100, 0, 32'h0, 32'h0));

    for (int i = 0; i < 80; i++) begin
      v.op   = 4'($urandom_range(0, 10));
      v.a    = $urandom;
      v.wd   = $urandom;
      v.rw   = $urandom;
      v.dly  = $urandom_range(0, 5);
      v.poke = bit'($urandom_range(0, 1));
      apply_check($sformatf("rnd%0d", i), model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
